// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: requester-side and DMA-side signals of the DMA arbiter.
// The slave modport is the arbiter's view. The master modport is the view
// of whatever drives the requests and observes the DMA port.
interface dma_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   dma_enable;
    logic                   dma_rw;
    logic [ADDR_W-1:0]      dma_address;
    logic [DATA_W-1:0]      dma_input_data;
    logic                   busy;

    modport slave (
        input  req, req_rw, req_addr, req_wdata,
        output grant, done, dma_enable, dma_rw, dma_address, dma_input_data, busy
    );

    modport master (
        output req, req_rw, req_addr, req_wdata,
        input  grant, done, dma_enable, dma_rw, dma_address, dma_input_data, busy
    );
endinterface

// File: rtl/dma_arbiter.sv
// dma_arbiter: one-transaction-at-a-time owner of the shared DMA port.
// Requester 0 = load block, 1 = CNN fetch, 2 = CNN write-back.
// Each won request is latched, issued as a one-cycle dma_enable pulse,
// timed over DMA_LAT cycles and acknowledged with a one-cycle done pulse.
// Optional feature macro ARB_ROUND_ROBIN_EN: when defined, arbitration is
// round-robin starting after the last winner; otherwise it is fixed
// priority with the lowest index winning.
module dma_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DMA_LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    dma_arbiter_if.slave   bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (DMA_LAT > 1) ? $clog2(DMA_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  winIdx;
    logic              anyReq;
    logic [CNT_W-1:0]  waitCnt;
    logic [NREQ-1:0]   grantQ;
    logic [NREQ-1:0]   doneQ;
    logic              enableQ;
    logic              rwQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] dataQ;

    assign anyReq = |bus.req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rrPtr;

    // Winner search starts at rrPtr; descending offsets let the nearest one win.
    always_comb begin
        winIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(rrPtr) + k) % NREQ]) begin
                winIdx = IDX_W'((int'(rrPtr) + k) % NREQ);
            end
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        winIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                winIdx = IDX_W'(k);
            end
        end
    end
`endif

    // Transaction FSM; every output is registered here and inputs are ignored
    // outside IDLE so an issued transaction always runs to its done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grantQ  <= '0;
            doneQ   <= '0;
            enableQ <= 1'b0;
            rwQ     <= 1'b0;
            addrQ   <= '0;
            dataQ   <= '0;
            waitCnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rrPtr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantQ  <= NREQ'(1) << winIdx;
                        enableQ <= 1'b1;
                        rwQ     <= bus.req_rw[winIdx];
                        addrQ   <= bus.req_addr[winIdx * ADDR_W +: ADDR_W];
                        dataQ   <= bus.req_wdata[winIdx * DATA_W +: DATA_W];
`ifdef ARB_ROUND_ROBIN_EN
                        rrPtr   <= (int'(winIdx) == NREQ - 1) ? '0 : winIdx + 1'b1;
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    enableQ <= 1'b0;
                    waitCnt <= CNT_W'(DMA_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        doneQ <= grantQ;
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                DONE: begin
                    doneQ  <= '0;
                    grantQ <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant          = grantQ;
    assign bus.done           = doneQ;
    assign bus.dma_enable     = enableQ;
    assign bus.dma_rw         = rwQ;
    assign bus.dma_address    = addrQ;
    assign bus.dma_input_data = dataQ;
    assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: two arbiter instances (DMA_LAT=2 and DMA_LAT=1) share one
// stimulus; a transaction-phase model predicts every output each cycle and
// directed scenarios pin the model with hand-computed values.
module tb_dma_arbiter;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  reqRw;
    logic [47:0] reqAddr;
    logic [47:0] reqWdata;

    int nChecks = 0;
    int nFails  = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    dma_arbiter_if #(.NREQ(3), .ADDR_W(16), .DATA_W(16)) bus2 ();
    dma_arbiter_if #(.NREQ(3), .ADDR_W(16), .DATA_W(16)) bus1 ();

    assign bus2.req = req;  assign bus2.req_rw = reqRw;
    assign bus2.req_addr = reqAddr;  assign bus2.req_wdata = reqWdata;
    assign bus1.req = req;  assign bus1.req_rw = reqRw;
    assign bus1.req_addr = reqAddr;  assign bus1.req_wdata = reqWdata;

    dma_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(16), .DMA_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    dma_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(16), .DMA_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    // Actual outputs gathered per instance (0: DMA_LAT=2, 1: DMA_LAT=1)
    logic [2:0]  aGrant[NI], aDone[NI];
    logic        aEn[NI], aRw[NI], aBusy[NI];
    logic [15:0] aAddr[NI], aData[NI];
    assign aGrant[0] = bus2.grant;  assign aGrant[1] = bus1.grant;
    assign aDone[0]  = bus2.done;   assign aDone[1]  = bus1.done;
    assign aEn[0]    = bus2.dma_enable; assign aEn[1] = bus1.dma_enable;
    assign aRw[0]    = bus2.dma_rw; assign aRw[1]    = bus1.dma_rw;
    assign aBusy[0]  = bus2.busy;   assign aBusy[1]  = bus1.busy;
    assign aAddr[0]  = bus2.dma_address;    assign aAddr[1] = bus1.dma_address;
    assign aData[0]  = bus2.dma_input_data; assign aData[1] = bus1.dma_input_data;

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s inst=%0d got=0x%0h want=0x%0h at t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction is (winner, start phase); outputs follow
    // from the number of cycles elapsed since the winning request was sampled.
    int          lat[NI] = '{2, 1};
    logic        mAct[NI];
    int          mPh[NI];
    int          mWin[NI];
    int          mPtr[NI];
    logic        mRw[NI];
    logic [15:0] mAddr[NI], mData[NI];

    function automatic int pick(input logic [2:0] r, input int ptr);
        int idx;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin
            idx = (ptr + k) % 3;
            if (r[idx]) return idx;
        end
`else
        for (int k = 0; k < 3; k++) begin
            idx = k;
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mAct[i] = 1'b0; mPh[i] = 0; mWin[i] = 0; mPtr[i] = 0;
                mRw[i] = 1'b0; mAddr[i] = '0; mData[i] = '0;
            end else if (!mAct[i]) begin
                if (req != 3'b000) begin
                    mWin[i]  = pick(req, mPtr[i]);
                    mPtr[i]  = (mWin[i] + 1) % 3;
                    mAct[i]  = 1'b1;
                    mPh[i]   = 1;
                    mRw[i]   = reqRw[mWin[i]];
                    mAddr[i] = reqAddr[mWin[i]*16 +: 16];
                    mData[i] = reqWdata[mWin[i]*16 +: 16];
                end
            end else if (mPh[i] == lat[i] + 2) begin
                mAct[i] = 1'b0;
            end else begin
                mPh[i]++;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                check("grant", i, {61'd0, aGrant[i]}, mAct[i] ? 64'(3'b001 << mWin[i]) : 64'd0);
                check("done", i, {61'd0, aDone[i]},
                      (mAct[i] && mPh[i] == lat[i] + 2) ? 64'(3'b001 << mWin[i]) : 64'd0);
                check("dma_enable", i, {63'd0, aEn[i]}, {63'd0, (mAct[i] && mPh[i] == 1)});
                check("busy", i, {63'd0, aBusy[i]}, {63'd0, mAct[i]});
                check("dma_rw", i, {63'd0, aRw[i]}, {63'd0, mRw[i]});
                check("dma_address", i, {48'd0, aAddr[i]}, {48'd0, mAddr[i]});
                check("dma_input_data", i, {48'd0, aData[i]}, {48'd0, mData[i]});
            end
        end
    end

    function automatic int ohIdx(input logic [2:0] g);
        for (int k = 0; k < 3; k++) if (g[k]) return k;
        return -1;
    endfunction

    int expOrd[4];
    int enCyc[4];
    int enWin[4];
    int nEn;

    task automatic idleGap(input int n);
        req = 3'b000;
        repeat (n) @(negedge clk);
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        expOrd = '{0, 1, 2, 0};
`else
        expOrd = '{0, 0, 0, 0};
`endif
        reset = 1'b1; req = '0; reqRw = '0; reqAddr = '0; reqWdata = '0;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("reset_grant", 0, {61'd0, bus2.grant}, 64'd0);
        check("reset_busy", 0, {63'd0, bus2.busy}, 64'd0);
        check("reset_addr", 0, {48'd0, bus2.dma_address}, 64'd0);
        reset = 1'b0;
        idleGap(2);

        // Single read on requester 1 (both latencies)
        req = 3'b010; reqRw = 3'b010; reqAddr[16 +: 16] = 16'h0010;
        @(posedge clk); @(negedge clk);                       // cycle 1
        check("rd_grant_c1", 0, {61'd0, bus2.grant}, 64'h2);
        check("rd_en_c1", 0, {63'd0, bus2.dma_enable}, 64'h1);
        check("rd_addr_c1", 0, {48'd0, bus2.dma_address}, 64'h0010);
        check("rd_rw_c1", 0, {63'd0, bus2.dma_rw}, 64'h1);
        @(negedge clk); @(negedge clk);                       // cycle 3
        check("lat1_done_c3", 1, {61'd0, bus1.done}, 64'h2);
        @(negedge clk);                                       // cycle 4
        check("rd_done_c4", 0, {61'd0, bus2.done}, 64'h2);
        check("lat1_grant_c4", 1, {61'd0, bus1.grant}, 64'h0);
        req = 3'b000;
        @(negedge clk);                                       // cycle 5
        check("rd_grant_c5", 0, {61'd0, bus2.grant}, 64'h0);
        idleGap(4);

        // Write on requester 2
        req = 3'b100; reqRw = 3'b000;
        reqAddr[32 +: 16] = 16'hC610; reqWdata[32 +: 16] = 16'hBEEF;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("wr_rw", 0, {63'd0, bus2.dma_rw}, 64'h0);
            check("wr_addr", 0, {48'd0, bus2.dma_address}, 64'hC610);
            check("wr_data", 0, {48'd0, bus2.dma_input_data}, 64'hBEEF);
        end
        idleGap(4);

        // Contention: all three held for four transactions
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        req = 3'b111; reqRw = 3'b111; nEn = 0;
        for (int c = 0; c < 40 && nEn < 4; c++) begin
            @(negedge clk);
            if (bus2.dma_enable) begin
                enCyc[nEn] = c;
                enWin[nEn] = ohIdx(bus2.grant);
                nEn++;
            end
        end
        check("cont_count", 0, 64'(nEn), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < nEn) check("cont_order", k, 64'(enWin[k]), 64'(expOrd[k]));
        for (int k = 1; k < 4; k++)
            if (k < nEn) check("cont_spacing", k, 64'(enCyc[k] - enCyc[k-1]), 64'd5);
        idleGap(8);

        // Mid-transaction input changes are ignored
        req = 3'b010; reqRw = 3'b010; reqAddr[16 +: 16] = 16'h0010;
        @(posedge clk); @(negedge clk); @(negedge clk);       // cycle 2
        reqAddr[16 +: 16] = 16'h00FF; req = 3'b000;
        @(negedge clk);                                       // cycle 3
        check("mid_addr_c3", 0, {48'd0, bus2.dma_address}, 64'h0010);
        @(negedge clk);                                       // cycle 4
        check("mid_done_c4", 0, {61'd0, bus2.done}, 64'h2);
        check("mid_addr_c4", 0, {48'd0, bus2.dma_address}, 64'h0010);
        @(negedge clk); @(negedge clk);                       // cycle 6
        check("mid_nogrant", 0, {61'd0, bus2.grant}, 64'h0);
        check("mid_idle", 0, {63'd0, bus2.busy}, 64'h0);
        idleGap(3);

        // Reset during WAIT, held over a pending request
        req = 3'b010; reqRw = 3'b010;
        @(posedge clk); @(negedge clk); @(negedge clk);       // cycle 2
        reset = 1'b1; req = 3'b011;
        @(negedge clk);                                       // cycle 3
        check("rst_grant_c3", 0, {61'd0, bus2.grant}, 64'h0);
        check("rst_busy_c3", 0, {63'd0, bus2.busy}, 64'h0);
        check("rst_addr_c3", 0, {48'd0, bus2.dma_address}, 64'h0);
        @(negedge clk);                                       // cycle 4
        check("rst_nodone_c4", 0, {61'd0, bus2.done}, 64'h0);
        check("rst_prio_c4", 0, {61'd0, bus2.grant}, 64'h0);
        reset = 1'b0;
        @(negedge clk);                                       // cycle 5
        check("rst_regrant", 0, {61'd0, bus2.grant}, 64'h1);
        idleGap(8);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 79) == 0);
            for (int r = 0; r < 3; r++)
                if ($urandom_range(0, 3) == 0) req[r] = ~req[r];
            reqRw = 3'($urandom);
            if ($urandom_range(0, 1) == 1) reqAddr = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 1) == 1) reqWdata = {16'($urandom), 16'($urandom), 16'($urandom)};
        end
        reset = 1'b0;
        idleGap(8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
